// File: rtl/text_buffer.sv
// COLS x ROWS character cell buffer: cursor-driven write port, registered scan-out read port,
// hardware clear sweep. Define TEXT_BUFFER_ATTR_EN to store a per-cell attribute as well.
`timescale 1ns/1ps
module text_buffer #(
  parameter int unsigned        COLS      = 80,
  parameter int unsigned        ROWS      = 30,
  parameter int unsigned        CHAR_W    = 8,
  parameter logic [CHAR_W-1:0]  FILL_CHAR = 8'h20,
  parameter int unsigned        ATTR_W    = 4,
  localparam int unsigned       DEPTH     = COLS * ROWS,
  localparam int unsigned       ADDR_W    = $clog2(DEPTH),
  localparam int unsigned       COL_W     = $clog2(COLS),
  localparam int unsigned       ROW_W     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CHAR_W-1:0] rd_data,
`ifdef TEXT_BUFFER_ATTR_EN
  output logic [ATTR_W-1:0] rd_attr,
  input  logic [ATTR_W-1:0] wr_attr,
`endif
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              cur_set,
  input  logic [ROW_W-1:0]  cur_row,
  input  logic [COL_W-1:0]  cur_col,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor
);

`ifdef TEXT_BUFFER_ATTR_EN
  localparam bit ATTR_EN = 1'b1;
`else
  localparam bit ATTR_EN = 1'b0;
`endif
  localparam int unsigned MEM_W   = CHAR_W + (ATTR_EN ? ATTR_W : 0);
  localparam int unsigned ROW_WX  = ROW_W + 1;
  localparam int unsigned COL_WX  = COL_W + 1;
  localparam int unsigned ADDR_WX = ADDR_W + 1;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  COLS_A    = ADDR_W'(COLS);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W:0]     ROWS_X    = ROW_WX'(ROWS);
  localparam logic [COL_W:0]     COLS_X    = COL_WX'(COLS);
  localparam logic [ADDR_W:0]    DEPTH_X   = ADDR_WX'(DEPTH);
  localparam logic [CHAR_W-1:0]  NEWLINE   = CHAR_W'(8'h0A);
  // Zero-extension leaves the attribute field at 0 for swept cells.
  localparam logic [MEM_W-1:0]   FILL_WORD = MEM_W'(FILL_CHAR);

  typedef enum logic {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [MEM_W-1:0]    rd_q;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [MEM_W-1:0]    mem_wdata;
  logic [MEM_W-1:0]    wr_word;
  logic [MEM_W-1:0]    mem [DEPTH];

`ifdef TEXT_BUFFER_ATTR_EN
  assign wr_word = {wr_attr, wr_char};
`else
  assign wr_word = wr_char;
`endif

  assign wr_ready = (state_q == StIdle) && !clr_req && !cur_set;
  assign busy     = (state_q == StClear);
  assign cursor   = cursor_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = cursor_q;
    mem_wdata = wr_word;

    case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          ptr_d   = '0;
        end else if (cur_set) begin
          row_d = ({1'b0, cur_row} >= ROWS_X) ? '0 : cur_row;
          col_d = ({1'b0, cur_col} >= COLS_X) ? '0 : cur_col;
        end else if (wr_valid) begin
          if (wr_char == NEWLINE) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
          end else begin
            mem_we = 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = FILL_WORD;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = StIdle;
          ptr_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    cursor_d = ADDR_W'(row_d) * COLS_A + ADDR_W'(col_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      cursor_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cursor_q <= cursor_d;
      ptr_q    <= ptr_d;
    end
  end

  // Cell array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if ({1'b0, rd_addr} < DEPTH_X) begin
      rd_q <= mem[rd_addr];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_data = rd_q[CHAR_W-1:0];
`ifdef TEXT_BUFFER_ATTR_EN
  assign rd_attr = rd_q[MEM_W-1:CHAR_W];
`endif

endmodule
